// File: rtl/fifo_status_ctrl_if.sv
// ============================================================================
// Module   : fifo_status_ctrl_if
// Brief    : Request, pointer and status bundle for the FIFO status controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_status_ctrl_if #(
    parameter int PTR_SIZE = 3
);
    logic                wr_req;
    logic                rd_req;
    logic [PTR_SIZE:0]   wr_ptr;
    logic [PTR_SIZE:0]   rd_ptr;
    logic                err_clr;
    logic                full;
    logic                empty;
    logic                almost_full;
    logic                almost_empty;
    logic [PTR_SIZE:0]   fill_level;
    logic                overflow;
    logic                underflow;
    logic                ptr_mismatch;

    modport master (
        output wr_req, rd_req, wr_ptr, rd_ptr, err_clr,
        input  full, empty, almost_full, almost_empty, fill_level,
               overflow, underflow, ptr_mismatch
    );

    modport slave (
        input  wr_req, rd_req, wr_ptr, rd_ptr, err_clr,
        output full, empty, almost_full, almost_empty, fill_level,
               overflow, underflow, ptr_mismatch
    );
endinterface

`default_nettype wire

// File: rtl/fifo_status_ctrl.sv
// ============================================================================
// Module   : fifo_status_ctrl
// Brief    : FIFO occupancy counter with registered full/empty/almost flags,
//            sticky overflow/underflow errors and a pointer-consistency check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_status_ctrl #(
    parameter int OSTD_NUM      = 8,
    parameter int PTR_SIZE      = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             clk_in,
    input  logic             sreset,
    fifo_status_ctrl_if.slave bus
);
    localparam int W = PTR_SIZE + 1;
    localparam logic [W-1:0] C_DEPTH  = W'(OSTD_NUM);
    localparam logic [W-1:0] C_AFULL  = W'(AFULL_THRESH);
    localparam logic [W-1:0] C_AEMPTY = W'(AEMPTY_THRESH);
    localparam logic [W-1:0] C_ONE    = W'(1);
    localparam logic [W-1:0] C_ZERO   = '0;

    logic         wr_acc;
    logic         rd_acc;
    logic [W-1:0] fill_nxt;
    logic [W-1:0] ptr_diff;

    // Acceptance mirrors the pointer updaters so the count tracks them exactly.
    always_comb begin
        wr_acc   = bus.wr_req & ~bus.full;
        rd_acc   = bus.rd_req & ~bus.empty;
        fill_nxt = bus.fill_level;
        case ({wr_acc, rd_acc})
            2'b10:   fill_nxt = bus.fill_level + C_ONE;
            2'b01:   fill_nxt = bus.fill_level - C_ONE;
            default: fill_nxt = bus.fill_level;
        endcase
        ptr_diff = bus.wr_ptr - bus.rd_ptr;
    end

    always_ff @(posedge clk_in) begin
        if (sreset) begin
            bus.fill_level   <= C_ZERO;
            bus.full         <= 1'b0;
            bus.empty        <= 1'b1;
            bus.almost_full  <= 1'b0;
            bus.almost_empty <= 1'b1;
            bus.overflow     <= 1'b0;
            bus.underflow    <= 1'b0;
            bus.ptr_mismatch <= 1'b0;
        end else begin
            bus.fill_level   <= fill_nxt;
            bus.full         <= (fill_nxt == C_DEPTH);
            bus.empty        <= (fill_nxt == C_ZERO);
            bus.almost_full  <= (fill_nxt >= C_AFULL);
            bus.almost_empty <= (fill_nxt <= C_AEMPTY);
            // Sticky errors: a new set condition beats a simultaneous clear.
            bus.overflow     <= (bus.wr_req & bus.full) |
                                (bus.overflow & ~bus.err_clr);
            bus.underflow    <= (bus.rd_req & bus.empty) |
                                (bus.underflow & ~bus.err_clr);
            bus.ptr_mismatch <= (ptr_diff != bus.fill_level) |
                                (bus.ptr_mismatch & ~bus.err_clr);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_status_ctrl.sv
// ============================================================================
// Module   : tb_fifo_status_ctrl
// Brief    : Directed plus randomized check of fifo_status_ctrl against a
//            count-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_status_ctrl;
    localparam int DEPTH = 8;
    localparam int PW    = 3;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam int MODP  = 16;

    logic clk_in = 1'b0;
    logic sreset;
    always #5 clk_in = ~clk_in;

    fifo_status_ctrl_if #(.PTR_SIZE(PW)) bus ();

    fifo_status_ctrl #(
        .OSTD_NUM      (DEPTH),
        .PTR_SIZE      (PW),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .clk_in (clk_in),
        .sreset (sreset),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: an integer occupancy plus the updaters' pointers.
    int m_fill = 0;
    bit m_ovf  = 0;
    bit m_udf  = 0;
    bit m_mm   = 0;
    int wp_m   = 0;
    int rp_m   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("fill_level",   32'(bus.fill_level),   32'(m_fill));
        check_val("full",         32'(bus.full),         32'(m_fill == DEPTH));
        check_val("empty",        32'(bus.empty),        32'(m_fill == 0));
        check_val("almost_full",  32'(bus.almost_full),  32'(m_fill >= AF));
        check_val("almost_empty", 32'(bus.almost_empty), 32'(m_fill <= AE));
        check_val("overflow",     32'(bus.overflow),     32'(m_ovf));
        check_val("underflow",    32'(bus.underflow),    32'(m_udf));
        check_val("ptr_mismatch", 32'(bus.ptr_mismatch), 32'(m_mm));
    endtask

    task automatic cycle(input bit wr, input bit rd, input bit clr, input bit rst,
                         input bit bad_ptr = 1'b0,
                         input logic [PW:0] wpf = '0, input logic [PW:0] rpf = '0);
        bit wa;
        bit ra;
        bit cond;
        sreset      = rst;
        bus.wr_req  = wr;
        bus.rd_req  = rd;
        bus.err_clr = clr;
        bus.wr_ptr  = bad_ptr ? wpf : (PW+1)'(wp_m);
        bus.rd_ptr  = bad_ptr ? rpf : (PW+1)'(rp_m);
        if (rst) begin
            m_fill = 0; m_ovf = 0; m_udf = 0; m_mm = 0;
            wp_m = 0; rp_m = 0;
        end else begin
            wa    = wr && (m_fill < DEPTH);
            ra    = rd && (m_fill > 0);
            cond  = (((int'(bus.wr_ptr) - int'(bus.rd_ptr)) + MODP) % MODP) != m_fill;
            m_ovf = (wr && m_fill == DEPTH) || (m_ovf && !clr);
            m_udf = (rd && m_fill == 0)     || (m_udf && !clr);
            m_mm  = cond || (m_mm && !clr);
            m_fill = m_fill + int'(wa) - int'(ra);
            wp_m  = (wp_m + int'(wa)) % MODP;
            rp_m  = (rp_m + int'(ra)) % MODP;
        end
        @(posedge clk_in);
        #1;
        check_all();
    endtask

    initial begin
        sreset = 1'b1;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.err_clr = 1'b0;
        bus.wr_ptr = '0;   bus.rd_ptr = '0;

        // Reset with both requests active
        repeat (2) cycle(1, 1, 0, 1);

        // Fill to full, then overflow
        repeat (8) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check_val("ovf_after_9th_wr", 32'(bus.overflow), 32'd1);
        check_val("fill_held_at_8",   32'(bus.fill_level), 32'd8);

        // Clear collides with a new overflow: set wins
        cycle(1, 0, 1, 0);
        check_val("ovf_set_over_clr", 32'(bus.overflow), 32'd1);
        cycle(0, 0, 1, 0);

        // Both requests while full
        cycle(1, 1, 0, 0);
        check_val("both_at_full_fill", 32'(bus.fill_level), 32'd7);
        check_val("both_at_full_ovf",  32'(bus.overflow), 32'd1);

        // Drain and underflow, then clear
        repeat (7) cycle(0, 1, 0, 0);
        check_val("drained_empty", 32'(bus.empty), 32'd1);
        cycle(0, 1, 0, 0);
        check_val("udf_set", 32'(bus.underflow), 32'd1);
        cycle(0, 0, 1, 0);
        check_val("udf_cleared", 32'(bus.underflow), 32'd0);

        // Both requests while empty
        cycle(1, 1, 0, 0);
        check_val("both_at_empty_fill", 32'(bus.fill_level), 32'd1);
        check_val("both_at_empty_udf",  32'(bus.underflow), 32'd1);
        cycle(0, 0, 1, 0);

        // Steady fill under simultaneous traffic
        repeat (3) cycle(1, 0, 0, 0);
        repeat (5) cycle(1, 1, 0, 0);
        check_val("fill_steady_4", 32'(bus.fill_level), 32'd4);

        // Forced pointer disagreement at fill 3
        cycle(0, 1, 0, 0);
        check_val("no_mismatch_consistent", 32'(bus.ptr_mismatch), 32'd0);
        cycle(0, 0, 0, 0, 1'b1, 4'd5, 4'd0);
        check_val("mismatch_set", 32'(bus.ptr_mismatch), 32'd1);
        cycle(0, 0, 1, 0);

        // Reset mid-operation at fill 5 with overflow set
        repeat (5) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 1, 0, 0);
        check_val("pre_reset_fill", 32'(bus.fill_level), 32'd5);
        cycle(1, 1, 0, 1);
        check_val("mid_reset_fill", 32'(bus.fill_level), 32'd0);
        check_val("mid_reset_ovf",  32'(bus.overflow), 32'd0);
        repeat (2) cycle(1, 0, 0, 0);
        check_val("count_from_zero", 32'(bus.fill_level), 32'd2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit wr, rd, clr, rst, bp;
            wr  = ($urandom_range(0, 99) < 55);
            rd  = ($urandom_range(0, 99) < 50);
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 63) == 0);
            bp  = ($urandom_range(0, 31) == 0);
            cycle(wr, rd, clr, rst, bp, 4'($urandom), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
